ssd1306_digit_writer: RTL and testbench

Downstream consumer of the BCD counter and an upstream peer of ssd1306_init. Both feed the spi driver.
On each update request after init is complete, the block snapshots the BCD digit vector and performs two SPI transfers:
- a column/page address window command group (DC=0);
- the glyph bitmap bytes for every digit (DC=1).
It drives the same command handshake as ssd1306_init and takes ownership of oled_dc and the SPI request lines once init_done is high.

---
 rtl/ssd1306_pkg.sv | 20 ++
 rtl/ssd1306_font_rom.sv | 41 ++++
 rtl/ssd1306_digit_writer.sv | 176 +++++++++++++++++
 tb/tb_ssd1306_digit_writer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - shared SSD1306 command constants, glyph geometry and writer states
package ssd1306_pkg;

    localparam logic [7:0] CMD_SET_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE_ADDR = 8'h22;
    localparam int         GLYPH_W           = 8;
    localparam int         CMD_BYTES         = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_SEND,
        ST_CMD_WAIT_BUSY,
        ST_CMD_WAIT_DONE,
        ST_DATA_SEND,
        ST_DATA_WAIT_BUSY,
        ST_DATA_WAIT_DONE,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/ssd1306_font_rom.sv
// rtl/ssd1306_font_rom.sv - 5x7 digit font in 8-column cells, bit0 = top pixel
// Glyph occupies columns 1..5; columns 0, 6 and 7 and codes >= 10 are blank.
module ssd1306_font_rom (
    input  logic [3:0] i_code,
    input  logic [2:0] i_col,
    output logic [7:0] o_byte
);

    logic [39:0] w_glyph;

    // Packed with column 5 in the top byte and column 1 in the bottom byte.
    always_comb begin
        w_glyph = 40'h0;
        case (i_code)
            4'd0: w_glyph = {8'h3E, 8'h45, 8'h49, 8'h51, 8'h3E};
            4'd1: w_glyph = {8'h00, 8'h40, 8'h7F, 8'h42, 8'h00};
            4'd2: w_glyph = {8'h46, 8'h49, 8'h51, 8'h61, 8'h42};
            4'd3: w_glyph = {8'h31, 8'h4B, 8'h45, 8'h41, 8'h21};
            4'd4: w_glyph = {8'h10, 8'h7F, 8'h12, 8'h14, 8'h18};
            4'd5: w_glyph = {8'h39, 8'h45, 8'h45, 8'h45, 8'h27};
            4'd6: w_glyph = {8'h30, 8'h49, 8'h49, 8'h4A, 8'h3C};
            4'd7: w_glyph = {8'h03, 8'h05, 8'h09, 8'h71, 8'h01};
            4'd8: w_glyph = {8'h36, 8'h49, 8'h49, 8'h49, 8'h36};
            4'd9: w_glyph = {8'h1E, 8'h29, 8'h49, 8'h49, 8'h06};
            default: w_glyph = 40'h0;
        endcase
    end

    always_comb begin
        o_byte = 8'h00;
        case (i_col)
            3'd1:    o_byte = w_glyph[7:0];
            3'd2:    o_byte = w_glyph[15:8];
            3'd3:    o_byte = w_glyph[23:16];
            3'd4:    o_byte = w_glyph[31:24];
            3'd5:    o_byte = w_glyph[39:32];
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/ssd1306_digit_writer.sv
// rtl/ssd1306_digit_writer.sv - redraws a BCD digit row on an SSD1306 via the shared SPI command handshake
// Sends a 6-byte address window (dc=0) then 8 glyph columns per digit (dc=1), most significant digit first.
module ssd1306_digit_writer
    import ssd1306_pkg::*;
#(
    parameter int DIGITS_NUM    = 6,
    parameter int COL_START     = 0,
    parameter int PAGE          = 0,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    enable_in,
    input  logic                    update_in,
    input  logic [4*DIGITS_NUM-1:0] digits_in,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    command_start,
    output logic [7:0]              command_out,
    output logic                    command_last_byte,
    input  logic                    command_ready,
    output logic                    oled_dc
);

    localparam int         DATA_BYTES = GLYPH_W * DIGITS_NUM;
    localparam int         IDX_W      = $clog2(DATA_BYTES + 1);
    localparam int         DIG_W      = IDX_W - 3;
    localparam logic [7:0] COL_END    = 8'(COL_START + DATA_BYTES - 1);

    if (COL_START + DATA_BYTES - 1 > 127) begin : g_col_range_check
        $error("ssd1306_digit_writer: digit row exceeds column 127");
    end

    state_e                    r_state;
    state_e                    w_next;
    logic [IDX_W-1:0]          r_idx;
    logic [4*DIGITS_NUM-1:0]   r_snapshot;
    logic                      r_dc;
    logic                      r_dc_settled;
    logic [DIGITS_NUM-1:0]     w_blank;
    logic [3:0]                w_code;
    logic [7:0]                w_font_byte;
    logic [7:0]                w_cmd_byte;
    logic                      w_cmd_last;
    logic                      w_data_last;

    ssd1306_font_rom u_font_rom (
        .i_code (w_code),
        .i_col  (r_idx[2:0]),
        .o_byte (w_font_byte)
    );

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic w_zero_run;
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int k = DIGITS_NUM - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (r_snapshot[4*k +: 4] == 4'd0);
            w_blank[k] = BLANK_LEADING && w_zero_run;
        end
    end

    always_comb begin
        w_code = 4'hF;
        for (int k = 0; k < DIGITS_NUM; k++) begin
            if (r_idx[IDX_W-1:3] == DIG_W'(DIGITS_NUM - 1 - k) && !w_blank[k]) begin
                w_code = r_snapshot[4*k +: 4];
            end
        end
    end

    always_comb begin
        w_cmd_byte = 8'h00;
        case (r_idx[2:0])
            3'd0:    w_cmd_byte = CMD_SET_COL_ADDR;
            3'd1:    w_cmd_byte = 8'(COL_START);
            3'd2:    w_cmd_byte = COL_END;
            3'd3:    w_cmd_byte = CMD_SET_PAGE_ADDR;
            3'd4:    w_cmd_byte = 8'(PAGE);
            3'd5:    w_cmd_byte = 8'(PAGE);
            default: w_cmd_byte = 8'h00;
        endcase
    end

    assign w_cmd_last  = (r_idx == IDX_W'(CMD_BYTES - 1));
    assign w_data_last = (r_idx == IDX_W'(DATA_BYTES - 1));

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_snapshot   <= '0;
            r_dc         <= 1'b0;
            r_dc_settled <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_dc_settled <= r_dc;
            if (r_state == ST_IDLE && w_next == ST_CMD_SEND) begin
                r_snapshot <= digits_in;
                r_idx      <= '0;
            end else if (r_state == ST_CMD_WAIT_DONE && w_next == ST_DATA_SEND) begin
                r_idx <= '0;
                r_dc  <= 1'b1;
            end else if ((r_state == ST_CMD_WAIT_DONE && w_next == ST_CMD_SEND) ||
                         (r_state == ST_DATA_WAIT_DONE && w_next == ST_DATA_SEND)) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_next == ST_IDLE) begin
                r_dc <= 1'b0;
            end
        end
    end

    // Data bytes also wait for r_dc_settled so dc leads the first data strobe by a cycle.
    always_comb begin
        w_next            = r_state;
        command_start     = 1'b0;
        command_out       = 8'h00;
        command_last_byte = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (update_in && enable_in) w_next = ST_CMD_SEND;
            end
            ST_CMD_SEND: begin
                if (!enable_in) begin
                    w_next = ST_IDLE;
                end else if (command_ready) begin
                    command_start     = 1'b1;
                    command_out       = w_cmd_byte;
                    command_last_byte = w_cmd_last;
                    w_next            = ST_CMD_WAIT_BUSY;
                end
            end
            ST_CMD_WAIT_BUSY: begin
                if (!command_ready) w_next = ST_CMD_WAIT_DONE;
            end
            ST_CMD_WAIT_DONE: begin
                if (command_ready) begin
                    if (!enable_in)      w_next = ST_IDLE;
                    else if (w_cmd_last) w_next = ST_DATA_SEND;
                    else                 w_next = ST_CMD_SEND;
                end
            end
            ST_DATA_SEND: begin
                if (!enable_in) begin
                    w_next = ST_IDLE;
                end else if (command_ready && r_dc_settled) begin
                    command_start     = 1'b1;
                    command_out       = w_font_byte;
                    command_last_byte = w_data_last;
                    w_next            = ST_DATA_WAIT_BUSY;
                end
            end
            ST_DATA_WAIT_BUSY: begin
                if (!command_ready) w_next = ST_DATA_WAIT_DONE;
            end
            ST_DATA_WAIT_DONE: begin
                if (command_ready) begin
                    if (!enable_in)       w_next = ST_IDLE;
                    else if (w_data_last) w_next = ST_FINISH;
                    else                  w_next = ST_DATA_SEND;
                end
            end
            ST_FINISH: begin
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign busy       = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign frame_done = (r_state == ST_FINISH);
    assign oled_dc    = r_dc;

endmodule

// File: tb/tb_ssd1306_digit_writer.sv
// tb/tb_ssd1306_digit_writer.sv - directed self-checking bench for ssd1306_digit_writer
module tb_ssd1306_digit_writer;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        enable_in = 1'b0;
    logic        update_in = 1'b0;
    logic [23:0] digits_in = 24'h0;
    logic        busy;
    logic        frame_done;
    logic        command_start;
    logic [7:0]  command_out;
    logic        command_last_byte;
    logic        command_ready;
    logic        oled_dc;

    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    logic        hold_low = 1'b0;
    logic [7:0]  q_byte[$];
    logic        q_dc[$];
    logic        q_last[$];
    int          fd_cnt = 0;
    int          viol = 0;
    logic        prev_start = 1'b0;

    ssd1306_digit_writer dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .enable_in         (enable_in),
        .update_in         (update_in),
        .digits_in         (digits_in),
        .busy              (busy),
        .frame_done        (frame_done),
        .command_start     (command_start),
        .command_out       (command_out),
        .command_last_byte (command_last_byte),
        .command_ready     (command_ready),
        .oled_dc           (oled_dc)
    );

    always #5 clk_in = ~clk_in;

    // SPI driver model: busy for 16 cycles after every accepted byte.
    always @(posedge clk_in) begin
        if (command_start)     busy_cnt <= 16;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign command_ready = (busy_cnt == 0) && !hold_low;

    always @(negedge clk_in) begin
        if (command_start) begin
            q_byte.push_back(command_out);
            q_dc.push_back(oled_dc);
            q_last.push_back(command_last_byte);
            if (prev_start || !command_ready) viol++;
        end
        prev_start = command_start;
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] glyph_col(input logic [3:0] d, input int c);
        logic [39:0] g;
        g = 40'h0;
        case (d)
            4'd0: g = 40'h3E_51_49_45_3E;
            4'd1: g = 40'h00_42_7F_40_00;
            4'd2: g = 40'h42_61_51_49_46;
            4'd3: g = 40'h21_41_45_4B_31;
            4'd4: g = 40'h18_14_12_7F_10;
            4'd5: g = 40'h27_45_45_45_39;
            4'd6: g = 40'h3C_4A_49_49_30;
            4'd7: g = 40'h01_71_09_05_03;
            4'd8: g = 40'h36_49_49_49_36;
            4'd9: g = 40'h06_49_49_29_1E;
            default: g = 40'h0;
        endcase
        if (c < 1 || c > 5) return 8'h00;
        return g[8*(5-c) +: 8];
    endfunction

    task automatic clear_log();
        q_byte.delete();
        q_dc.delete();
        q_last.delete();
        fd_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic pulse_update();
        @(negedge clk_in);
        update_in = 1'b1;
        @(negedge clk_in);
        update_in = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk_in);
            if (q_byte.size() >= n) break;
        end
        check($sformatf("wait_bytes_%0d", n), (q_byte.size() >= n), 1);
    endtask

    task automatic wait_frame(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk_in);
            if (fd_cnt > 0 && !busy) break;
        end
        repeat (60) @(negedge clk_in);
    endtask

    // shown: one nibble per digit, most significant first; nibble F = blank cell.
    task automatic check_frame(input string tag, input logic [23:0] shown);
        logic [7:0] cmd [6];
        logic [3:0] d;
        int         n;
        cmd = '{8'h21, 8'h00, 8'h2F, 8'h22, 8'h00, 8'h00};
        check({tag, "_bytes"}, q_byte.size(), 54);
        check({tag, "_frame_done"}, fd_cnt, 1);
        check({tag, "_busy"}, busy, 0);
        n = (q_byte.size() < 54) ? q_byte.size() : 54;
        for (int i = 0; i < n; i++) begin
            if (i < 6) begin
                check($sformatf("%s_cmd%0d", tag, i), q_byte[i], cmd[i]);
                check($sformatf("%s_cmd%0d_dc", tag, i), q_dc[i], 0);
                check($sformatf("%s_cmd%0d_last", tag, i), q_last[i], (i == 5));
            end else begin
                d = shown[4*(5 - (i-6)/8) +: 4];
                check($sformatf("%s_dat%0d", tag, i-6), q_byte[i], glyph_col(d, (i-6) % 8));
                check($sformatf("%s_dat%0d_dc", tag, i-6), q_dc[i], 1);
                check($sformatf("%s_dat%0d_last", tag, i-6), q_last[i], (i == 53));
            end
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_start", command_start, 0);
        check("rst_out", command_out, 0);
        check("rst_last", command_last_byte, 0);
        check("rst_dc", oled_dc, 0);
        do_reset();

        // Frame content
        enable_in = 1'b1;
        digits_in = 24'h123456;
        clear_log();
        pulse_update();
        wait_frame(3000);
        check_frame("f123456", 24'h123456);

        // Leading-zero blanking
        digits_in = 24'h000042;
        clear_log();
        pulse_update();
        wait_frame(3000);
        check_frame("f42", 24'hFFFF42);

        digits_in = 24'h000000;
        clear_log();
        pulse_update();
        wait_frame(3000);
        check_frame("f0", 24'hFFFFF0);

        // Gating: update with enable low is ignored
        enable_in = 1'b0;
        clear_log();
        pulse_update();
        repeat (200) @(negedge clk_in);
        check("gate_bytes", q_byte.size(), 0);
        check("gate_busy", busy, 0);

        // Snapshot: digit change mid-frame does not tear
        enable_in = 1'b1;
        digits_in = 24'h111111;
        clear_log();
        pulse_update();
        wait_bytes(20, 1000);
        digits_in = 24'h999999;
        wait_frame(3000);
        check_frame("snap", 24'h111111);

        // Handshake: ready held low after reset, update while busy
        digits_in = 24'h123456;
        hold_low = 1'b1;
        do_reset();
        clear_log();
        pulse_update();
        repeat (50) @(negedge clk_in);
        check("hold_bytes", q_byte.size(), 0);
        check("hold_busy", busy, 1);
        hold_low = 1'b0;
        wait_bytes(10, 1000);
        pulse_update();
        wait_frame(3000);
        check_frame("hs", 24'h123456);
        check("hs_violations", viol, 0);

        // Abort during data byte 10
        clear_log();
        pulse_update();
        wait_bytes(16, 1000);
        enable_in = 1'b0;
        repeat (100) @(negedge clk_in);
        check("abort_bytes", q_byte.size(), 16);
        check("abort_frame_done", fd_cnt, 0);
        check("abort_busy", busy, 0);
        check("abort_dc", oled_dc, 0);
        enable_in = 1'b1;
        clear_log();
        pulse_update();
        wait_frame(3000);
        check_frame("post_abort", 24'h123456);

        // Asynchronous reset during command byte 3
        clear_log();
        pulse_update();
        wait_bytes(3, 1000);
        @(negedge clk_in);
        check("pre_rst_busy", busy, 1);
        #2 reset_in = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_start", command_start, 0);
        check("arst_out", command_out, 0);
        check("arst_last", command_last_byte, 0);
        check("arst_dc", oled_dc, 0);
        check("arst_frame_done", frame_done, 0);
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
        clear_log();
        pulse_update();
        wait_frame(3000);
        check_frame("post_rst", 24'h123456);
        check("final_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
